sha256_block_fetch: RTL and testbench

Memory-side message reader for the SHA-256 hash path. It acts as initiator on the single-port word memory interface (`mem_clk`/`mem_we`/`mem_addr`/`mem_read_data`). It reads a `NUM_OF_WORDS`-word message starting at `message_addr` and applies SHA-256 padding. It then delivers the padded message one 512-bit block at a time to the compression core over a valid/ready handshake. The block replaces the ad-hoc padding logic inside the hash core, so padding can be verified on its own.

---
 rtl/sha256_block_fetch.sv | 157 +++++++++++++++
 tb/tb_sha256_block_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_fetch.sv
// Reads an N-word message from word memory, applies SHA-256 padding and
// presents it one 512-bit block at a time over a valid/ready handshake.
module sha256_block_fetch #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic [7:0]   blk_index,
    output logic         blk_last,
    output logic         busy,
    output logic         done
);

    localparam int          NUM_BLOCKS = ((NUM_OF_WORDS + 2) / 16) + 1;
    localparam logic [7:0]  LAST_B     = 8'(NUM_BLOCKS - 1);
    localparam logic [15:0] N16        = 16'(NUM_OF_WORDS);
    localparam logic [31:0] LEN_BITS   = 32'(NUM_OF_WORDS * 32);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0]        r_base;
    logic [15:0]        r_mem_addr;
    logic [7:0]         r_b;
    logic [3:0]         r_j;
    logic               r_vld_p1;
    logic [3:0]         r_j_p1;
    logic [0:15][31:0]  r_words;

    logic [15:0]        w_g;
    logic [15:0]        w_g_p1;
    logic               w_last_blk;

    // Padding rule for one slot: message data, the 0x80 marker, then the bit length.
    function automatic logic [31:0] slot_word(
        input logic [15:0] g,
        input logic [3:0]  j,
        input logic        last,
        input logic [31:0] rd
    );
        if (g < N16)
            return rd;
        else if (g == N16)
            return 32'h8000_0000;
        else if (last && (j == 4'd15))
            return LEN_BITS;
        else
            return 32'h0;
    endfunction

    assign w_g        = {4'b0, r_b, r_j};
    assign w_g_p1     = {4'b0, r_b, r_j_p1};
    assign w_last_blk = (r_b == LAST_B);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_FETCH;
            S_FETCH:   if (r_j == 4'd15) w_next = S_FLUSH;
            S_FLUSH:   w_next = S_PRESENT;
            S_PRESENT: if (blk_ready) w_next = w_last_blk ? S_DONE : S_FETCH;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base     <= '0;
            r_mem_addr <= '0;
            r_b        <= '0;
            r_j        <= '0;
            r_vld_p1   <= 1'b0;
            r_j_p1     <= '0;
            r_words    <= '0;
        end else begin
            // p0 -> p1: address issued this cycle, data returns next cycle
            r_vld_p1 <= (r_state == S_FETCH);
            r_j_p1   <= r_j;
            // p1 capture: memory word for the slot issued one cycle earlier
            if (r_vld_p1)
                r_words[r_j_p1] <= slot_word(w_g_p1, r_j_p1, w_last_blk, mem_read_data);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base     <= message_addr;
                        r_mem_addr <= message_addr;
                        r_b        <= '0;
                        r_j        <= '0;
                    end else begin
                        r_mem_addr <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_j != 4'd15) begin
                        r_j        <= r_j + 4'd1;
                        r_mem_addr <= r_base + w_g + 16'd1;
                    end
                end
                S_PRESENT: begin
                    if (blk_ready) begin
                        if (!w_last_blk) begin
                            r_b        <= r_b + 8'd1;
                            r_j        <= '0;
                            r_mem_addr <= r_base + {4'b0, r_b + 8'd1, 4'b0};
                        end else begin
                            r_mem_addr <= '0;
                        end
                    end
                end
                S_DONE: begin
                    r_mem_addr <= '0;
                    r_b        <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mem_clk        = clk;
    assign mem_we         = 1'b0;
    assign mem_write_data = 32'h0;
    assign mem_addr       = r_mem_addr;
    assign blk_valid      = (r_state == S_PRESENT);
    assign blk_data       = r_words;
    assign blk_index      = r_b;
    assign blk_last       = blk_valid && w_last_blk;
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);

endmodule

// File: tb/tb_sha256_block_fetch.sv
// Directed bench for sha256_block_fetch: four instances (N = 30, 13, 14, 4)
// sharing one clock and reset, each with a rotate-pattern word memory.
module tb_sha256_block_fetch;

    localparam logic [31:0] SEED = 32'h0123_4675;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         st   [4];
    logic [15:0]  ma   [4];
    logic         rdy  [4];
    logic [31:0]  rd   [4];
    logic         mclk [4];
    logic         mwe  [4];
    logic [15:0]  addr [4];
    logic [31:0]  mwd  [4];
    logic         vld  [4];
    logic [511:0] data [4];
    logic [7:0]   idx  [4];
    logic         lst  [4];
    logic         bsy  [4];
    logic         dn   [4];

    generate
        for (genvar k = 0; k < 4; k++) begin : g_dut
            sha256_block_fetch #(
                .NUM_OF_WORDS(k == 0 ? 30 : k == 1 ? 13 : k == 2 ? 14 : 4)
            ) u_dut (
                .clk           (clk),
                .reset_n       (reset_n),
                .start         (st[k]),
                .message_addr  (ma[k]),
                .mem_clk       (mclk[k]),
                .mem_we        (mwe[k]),
                .mem_addr      (addr[k]),
                .mem_write_data(mwd[k]),
                .mem_read_data (rd[k]),
                .blk_valid     (vld[k]),
                .blk_ready     (rdy[k]),
                .blk_data      (data[k]),
                .blk_index     (idx[k]),
                .blk_last      (lst[k]),
                .busy          (bsy[k]),
                .done          (dn[k])
            );
        end
    endgenerate

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (32 - n));
    endfunction

    // Memory word at address a is SEED rotated left by a mod 32.
    function automatic logic [31:0] memf(input logic [15:0] a);
        return rotl(SEED, int'(a[4:0]));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) rd[i] <= memf(addr[i]);
    end

    function automatic logic [511:0] exp_blk(input int n, input logic [15:0] base,
                                             input int b, input int nb);
        logic [511:0] r;
        logic [31:0]  w;
        int           g;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            g = 16 * b + j;
            if (g < n)                     w = memf(base + 16'(g));
            else if (g == n)               w = 32'h8000_0000;
            else if (b == nb - 1 && j == 15) w = 32'(n * 32);
            else                           w = 32'h0;
            r[511 - 32 * j -: 32] = w;
        end
        return r;
    endfunction

    function automatic logic [31:0] word(input logic [511:0] x, input int j);
        return x[511 - 32 * j -: 32];
    endfunction

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [511:0] got   [4];
    int           gcyc  [4];
    logic [7:0]   gidx  [4];
    logic         glast [4];
    logic [15:0]  atrace[16];
    int           nblk, done_cyc, idle_cyc;

    // Pulse start with blk_ready high and log every presented block until idle.
    task automatic run(input int k, input logic [15:0] base);
        nblk = 0; done_cyc = -1; idle_cyc = -1;
        rdy[k] = 1'b1;
        ma[k]  = base;
        st[k]  = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            st[k] = 1'b0;
            if (c < 16) atrace[c] = addr[k];
            if (vld[k] && nblk < 4) begin
                got[nblk] = data[k]; gidx[nblk] = idx[k];
                glast[nblk] = lst[k]; gcyc[nblk] = c; nblk++;
            end
            if (dn[k] && done_cyc < 0) done_cyc = c;
            if (!bsy[k]) begin idle_cyc = c; break; end
        end
    endtask

    task automatic chk_reset(input int k, input string tag);
        chk({tag, "_valid"}, vld[k], 1'b0);
        chk({tag, "_data"},  data[k], '0);
        chk({tag, "_index"}, idx[k], 8'd0);
        chk({tag, "_last"},  lst[k], 1'b0);
        chk({tag, "_busy"},  bsy[k], 1'b0);
        chk({tag, "_done"},  dn[k], 1'b0);
        chk({tag, "_addr"},  addr[k], 16'd0);
        chk({tag, "_we"},    mwe[k], 1'b0);
        chk({tag, "_wdata"}, mwd[k], 32'd0);
    endtask

    initial begin
        logic [511:0] snap;
        logic [15:0]  sa;
        int           c;

        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin st[i] = 1'b0; ma[i] = '0; rdy[i] = 1'b1; end
        #1;
        chk_reset(0, "rst0");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Full run N = 30
        run(0, 16'h0000);
        chk("n30_nblk", nblk, 3);
        chk("n30_vcyc0", gcyc[0], 18);
        chk("n30_vcyc1", gcyc[1], 36);
        chk("n30_vcyc2", gcyc[2], 54);
        chk("n30_done_cyc", done_cyc, 55);
        chk("n30_idle_cyc", idle_cyc, 56);
        chk("n30_addr_c1", atrace[1], 16'h0000);
        chk("n30_addr_c5", atrace[5], 16'h0004);
        chk("n30_idx2", gidx[2], 8'd2);
        chk("n30_last0", glast[0], 1'b0);
        chk("n30_last2", glast[2], 1'b1);
        chk("n30_b0_w1", word(got[0], 1), 32'h0246_8CEA);
        chk("n30_b0", got[0], exp_blk(30, 16'h0, 0, 3));
        chk("n30_b1_w14", word(got[1], 14), 32'h8000_0000);
        chk("n30_b1_w15", word(got[1], 15), 32'h0);
        chk("n30_b1", got[1], exp_blk(30, 16'h0, 1, 3));
        chk("n30_b2", got[2], {480'b0, 32'h0000_03C0});

        // Back-to-back start with backpressure on block 0, start pulsed in PRESENT
        rdy[0] = 1'b0; ma[0] = 16'h0000; st[0] = 1'b1;
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            st[0] = 1'b0;
            if (vld[0]) begin c = i; break; end
        end
        chk("bp_first_valid_cyc", c, 18);
        snap = data[0]; sa = addr[0];
        chk("bp_b0", snap, exp_blk(30, 16'h0, 0, 3));
        chk("bp_addr_hold", sa, 16'h000F);
        for (int i = 0; i < 5; i++) begin
            st[0] = (i == 1);
            @(negedge clk);
            chk("bp_valid", vld[0], 1'b1);
            chk("bp_data", data[0], snap);
            chk("bp_addr", addr[0], sa);
            chk("bp_index", idx[0], 8'd0);
        end
        st[0] = 1'b0; rdy[0] = 1'b1;
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (vld[0]) begin c = i; break; end
        end
        chk("bp_next_valid_cyc", c, 18);
        chk("bp_b1", data[0], exp_blk(30, 16'h0, 1, 3));
        chk("bp_b1_index", idx[0], 8'd1);
        c = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (!bsy[0]) begin c = i; break; end
        end
        chk("bp_finished", c > 0, 1'b1);

        // Reset at FETCH slot 7, then a fresh run
        ma[0] = 16'h0000; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_addr_j7", addr[0], 16'h0007);
        chk("mid_busy", bsy[0], 1'b1);
        reset_n = 1'b0;
        #1;
        chk_reset(0, "rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", vld[0], 1'b0);
            chk("post_rst_busy", bsy[0], 1'b0);
        end
        run(0, 16'h0000);
        chk("rerun_nblk", nblk, 3);
        chk("rerun_b0", got[0], exp_blk(30, 16'h0, 0, 3));
        chk("rerun_b1", got[1], exp_blk(30, 16'h0, 1, 3));
        chk("rerun_b2", got[2], {480'b0, 32'h0000_03C0});
        chk("rerun_done_cyc", done_cyc, 55);

        // N = 13: single block
        run(1, 16'h0000);
        chk("n13_nblk", nblk, 1);
        chk("n13_last", glast[0], 1'b1);
        chk("n13_w12", word(got[0], 12), rotl(SEED, 12));
        chk("n13_w13", word(got[0], 13), 32'h8000_0000);
        chk("n13_w14", word(got[0], 14), 32'h0);
        chk("n13_w15", word(got[0], 15), 32'h0000_01A0);
        chk("n13_done_cyc", done_cyc, 19);

        // N = 14: two blocks
        run(2, 16'h0000);
        chk("n14_nblk", nblk, 2);
        chk("n14_b0_w14", word(got[0], 14), 32'h8000_0000);
        chk("n14_b0_w15", word(got[0], 15), 32'h0);
        chk("n14_b1", got[1], {480'b0, 32'h0000_01C0});
        chk("n14_last1", glast[1], 1'b1);
        chk("n14_done_cyc", done_cyc, 37);

        // N = 4 from 0xFFFE: address wraps
        run(3, 16'hFFFE);
        chk("wrap_a1", atrace[1], 16'hFFFE);
        chk("wrap_a2", atrace[2], 16'hFFFF);
        chk("wrap_a3", atrace[3], 16'h0000);
        chk("wrap_a4", atrace[4], 16'h0001);
        chk("wrap_nblk", nblk, 1);
        chk("wrap_w0", word(got[0], 0), 32'h4048_D19D);
        chk("wrap_w2", word(got[0], 2), SEED);
        chk("wrap_w4", word(got[0], 4), 32'h8000_0000);
        chk("wrap_w15", word(got[0], 15), 32'h0000_0080);
        chk("wrap_blk", got[0], exp_blk(4, 16'hFFFE, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
